// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, address type and the PC reset vector.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  // Base of the instruction memory region; fetch starts here out of reset.
  localparam addr_t PC_RESET_VALUE = 32'h0100_0000;

endpackage : rv32i_pkg

// File: rtl/program_counter.sv
// Program counter register for the RV32I single-cycle core.
// Loads the next-PC value every rising edge and returns to the reset vector
// asynchronously while reset is low. The output comes straight from the
// register, so there is no combinational path from next_pc to current_pc.
module program_counter #(
  parameter int               XLEN          = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC      = rv32i_pkg::PC_RESET_VALUE,
  parameter bit               ALIGN_MASK_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,      // asynchronous, active low
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] current_pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // The reset vector must be a legal fetch address when the low bits are masked.
  if (ALIGN_MASK_EN && (RESET_PC[1:0] != 2'b00)) begin : g_reset_pc_misaligned
    $error("program_counter: RESET_PC %h is not word aligned", RESET_PC);
  end

  // Next-state value: optionally clear the byte-offset bits (no compressed ISA).
  always_comb begin
    pc_d = next_pc;
    if (ALIGN_MASK_EN) begin
      pc_d = {next_pc[XLEN-1:2], 2'b00};
    end
  end

  // PC register; reset wins over any coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign current_pc = pc_q;

  // An unknown next_pc at a live edge means the upstream next-PC mux is broken.
  a_next_pc_known : assert property (@(posedge clk) disable iff (!reset)
    !$isunknown(next_pc))
    else $error("program_counter: next_pc has X/Z bits at a clock edge");

  // Low bits get masked anyway, but a nonzero offset points at an upstream bug.
  a_next_pc_aligned : assert property (@(posedge clk) disable iff (!reset)
    (ALIGN_MASK_EN == 1'b0) || (next_pc[1:0] == 2'b00))
    else $warning("program_counter: next_pc %h has nonzero low bits, masked", next_pc);

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed plus randomized checks of program_counter, with and without the
// alignment mask, against a simple address-level reference model.
module tb_program_counter;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] next_pc = 32'h0100_0000;
  logic [31:0] pc_mask;
  logic [31:0] pc_raw;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_counter #(.XLEN(32), .RESET_PC(RST_PC), .ALIGN_MASK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .current_pc(pc_mask)
  );

  program_counter #(.XLEN(32), .RESET_PC(RST_PC), .ALIGN_MASK_EN(1'b0)) dut_nomask (
    .clk(clk), .reset(reset), .next_pc(next_pc), .current_pc(pc_raw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Both instances must show the reset vector.
  task automatic check_reset(input string tag);
    check({tag, "_mask"}, pc_mask, RST_PC);
    check({tag, "_raw"},  pc_raw,  RST_PC);
  endtask

  // Present an address, clock it in, and compare against the model:
  // word-aligned fetch clears the two byte-offset bits, otherwise verbatim.
  task automatic step(input string tag, input logic [31:0] addr);
    next_pc = addr;
    @(posedge clk);
    #1;
    check({tag, "_mask"}, pc_mask, addr & 32'hFFFF_FFFC);
    check({tag, "_raw"},  pc_raw,  addr);
  endtask

  // Low pulse between edges: PC returns to the vector with no clock edge.
  task automatic async_reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check_reset({tag, "_low"});
    #1;
    reset = 1'b1;
    #1;
    check_reset({tag, "_released"});
  endtask

  initial begin
    logic [31:0] addr;

    // Reset at start, held across an edge.
    #1;
    reset = 1'b0;
    #1;
    check_reset("reset_before_edge");
    @(posedge clk);
    #1;
    check_reset("reset_after_edge");

    // Release and first load.
    reset = 1'b1;
    step("release_load", 32'h0100_0000);

    // Sequential fetch.
    step("seq_4", 32'h0100_0004);
    step("seq_8", 32'h0100_0008);
    step("seq_c", 32'h0100_000C);

    // Asynchronous reset between edges with PC at ...08.
    step("pre_async", 32'h0100_0008);
    async_reset_pulse("async");
    step("after_async", 32'h0100_0010);

    // Jump target and top-of-space boundary.
    step("jump", 32'h0100_0400);
    step("top", 32'hFFFF_FFFC);

    // Misaligned target: masked in one instance, verbatim in the other.
    step("misaligned", 32'h0100_0006);

    // Reset asserted right at a clock edge: reset wins.
    next_pc = 32'h0200_0000;
    @(posedge clk);
    reset = 1'b0;
    #1;
    check_reset("reset_at_edge");
    #2;
    reset = 1'b1;
    step("after_edge_reset", 32'h0200_0000);

    // Randomized fetch stream with occasional asynchronous reset pulses.
    for (int i = 0; i < 60; i++) begin
      addr = $urandom;
      step($sformatf("rand_%0d", i), addr);
      if ($urandom_range(0, 7) == 0) begin
        async_reset_pulse($sformatf("rand_rst_%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_program_counter
